fetch_stage: RTL and testbench

//  Instruction fetch stage: owns the PC and drives the icache lookup (addr/enable).

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage_sat_counter.sv | 23 ++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: address/instruction widths, FSM states and the IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned PHY_LEN  = 20;
    localparam int unsigned INST_LEN = 32;
    localparam logic [PHY_LEN-1:0] RESET_PC_DEFAULT = 20'h00000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic                valid;
        logic                exc;
        logic [PHY_LEN-1:0]  pc;
        logic [INST_LEN-1:0] instr;
    } if_id_t;

    // IF/ID entry carrying an instruction-address-misaligned fault for target pc
    function automatic if_id_t fault_entry(input logic [PHY_LEN-1:0] pc);
        if_id_t e;
        e.valid = 1'b1;
        e.exc   = 1'b1;
        e.pc    = pc;
        e.instr = '0;
        return e;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode/execute control, icache lookup and IF/ID outputs.
interface fetch_stage_if #(
    parameter int unsigned CNT_W = 32
);
    import fetch_stage_pkg::*;

    logic                stall_i;
    logic                redirect_i;
    logic [PHY_LEN-1:0]  redirect_pc_i;
    logic [PHY_LEN-1:0]  ic_addr_o;
    logic                ic_enable_o;
    logic [INST_LEN-1:0] ic_instr_i;
    logic                ic_miss_i;
    logic                if_valid_o;
    logic [INST_LEN-1:0] if_instr_o;
    logic [PHY_LEN-1:0]  if_pc_o;
    logic                if_exc_o;
    logic [CNT_W-1:0]    cnt_fetch_o;
    logic [CNT_W-1:0]    cnt_miss_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, ic_instr_i, ic_miss_i,
        output ic_addr_o, ic_enable_o, if_valid_o, if_instr_o, if_pc_o, if_exc_o,
               cnt_fetch_o, cnt_miss_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, ic_instr_i, ic_miss_i,
        input  ic_addr_o, ic_enable_o, if_valid_o, if_instr_o, if_pc_o, if_exc_o,
               cnt_fetch_o, cnt_miss_o
    );

endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives icache lookups and loads the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PHY_LEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned        CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t       r_state, w_state_nxt;
    logic [PHY_LEN-1:0] r_pc, w_pc_nxt;
    if_id_t             r_ifid, w_ifid_nxt;
    logic               w_hit;
    logic               w_miss_cyc;
    logic               w_redir_aligned;
    logic [CNT_W-1:0]   w_cnt_fetch;
    logic [CNT_W-1:0]   w_cnt_miss;

    assign w_redir_aligned = (bus.redirect_pc_i[1:0] == 2'b00);
    assign w_miss_cyc      = (r_state == ST_RUN) && bus.ic_miss_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_ifid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ifid  <= w_ifid_nxt;
        end
    end

    // Per-cycle priority in RUN: redirect > stall > miss > hit
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ifid_nxt  = r_ifid;
        w_hit       = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.redirect_i) begin
                    if (w_redir_aligned) begin
                        w_pc_nxt         = bus.redirect_pc_i;
                        w_ifid_nxt.valid = 1'b0;
                    end else begin
                        w_ifid_nxt  = fault_entry(bus.redirect_pc_i);
                        w_state_nxt = ST_HALT;
                    end
                end else if (!bus.stall_i) begin
                    if (bus.ic_miss_i) begin
                        w_ifid_nxt.valid = 1'b0;
                    end else begin
                        w_hit            = 1'b1;
                        w_ifid_nxt.valid = 1'b1;
                        w_ifid_nxt.exc   = 1'b0;
                        w_ifid_nxt.pc    = r_pc;
                        w_ifid_nxt.instr = bus.ic_instr_i;
                        w_pc_nxt         = r_pc + PHY_LEN'(4);
                    end
                end
            end
            ST_HALT: begin
                if (bus.redirect_i) begin
                    if (w_redir_aligned) begin
                        w_pc_nxt         = bus.redirect_pc_i;
                        w_ifid_nxt.valid = 1'b0;
                        w_state_nxt      = ST_RUN;
                    end else begin
                        w_ifid_nxt = fault_entry(bus.redirect_pc_i);
                    end
                end else if (!bus.stall_i) begin
                    w_ifid_nxt.valid = 1'b0;
                end
            end
            default: ;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cnt_fetch (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_hit),
        .o_count (w_cnt_fetch)
    );

    sat_counter #(.W(CNT_W)) u_cnt_miss (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_miss_cyc),
        .o_count (w_cnt_miss)
    );

    assign bus.ic_addr_o   = r_pc;
    assign bus.ic_enable_o = (r_state == ST_RUN);
    assign bus.if_valid_o  = r_ifid.valid;
    assign bus.if_exc_o    = r_ifid.exc;
    assign bus.if_pc_o     = r_ifid.pc;
    assign bus.if_instr_o  = r_ifid.instr;
    assign bus.cnt_fetch_o = w_cnt_fetch;
    assign bus.cnt_miss_o  = w_cnt_miss;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random traffic against a reference model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int unsigned CNT_W   = 32;
    localparam longint      CNT_MAX = longint'((64'd1 << CNT_W) - 64'd1);
    localparam int          M_BOOT  = 0;
    localparam int          M_RUN   = 1;
    localparam int          M_HALT  = 2;

    logic clk = 1'b0;
    logic rst;
    logic sat_inc;
    logic [2:0] sat_cnt;

    always #5 clk = ~clk;

    fetch_stage_if #(.CNT_W(CNT_W)) bus ();

    fetch_stage #(.RESET_PC(20'h00000), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sat_counter #(.W(3)) u_sat (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (sat_inc),
        .o_count (sat_cnt)
    );

    // icache stub: data is a recognisable function of the lookup address
    assign bus.ic_instr_i = {12'hC3A, bus.ic_addr_o};

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_mode;
    logic [19:0] m_pc;
    logic        m_v, m_e;
    logic [19:0] m_ipc;
    logic [31:0] m_ins;
    longint      m_cf, m_cm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat_inc_m(input longint x);
        return (x >= CNT_MAX) ? CNT_MAX : x + 1;
    endfunction

    task automatic model(input bit rs, input bit rd, input logic [19:0] rpc,
                         input bit st, input bit ms);
        if (rs) begin
            m_mode = M_BOOT; m_pc = 20'h0; m_v = 0; m_e = 0; m_ipc = 0; m_ins = 0;
            m_cf = 0; m_cm = 0;
            return;
        end
        if (m_mode == M_RUN && ms) m_cm = sat_inc_m(m_cm);
        if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (rd && (rpc % 4 == 0)) begin
            m_pc = rpc; m_v = 0; m_mode = M_RUN;
        end else if (rd) begin
            m_v = 1; m_e = 1; m_ipc = rpc; m_ins = 0; m_mode = M_HALT;
        end else if (st) begin
            // decode holds everything
        end else if (m_mode == M_HALT || ms) begin
            m_v = 0;
        end else begin
            m_v = 1; m_e = 0; m_ipc = m_pc; m_ins = {12'hC3A, m_pc};
            m_pc = 20'((32'(m_pc) + 4) % (1 << 20));
            m_cf = sat_inc_m(m_cf);
        end
    endtask

    // One clock: drive inputs, check lookup side mid-cycle, check registered side after the edge
    task automatic step(input bit rs, input bit rd, input logic [19:0] rpc,
                        input bit st, input bit ms);
        rst = rs; bus.redirect_i = rd; bus.redirect_pc_i = rpc;
        bus.stall_i = st; bus.ic_miss_i = ms;
        @(negedge clk);
        if (!rs) begin
            chk("ic_addr", 64'(bus.ic_addr_o), 64'(m_pc));
            chk("ic_enable", 64'(bus.ic_enable_o), 64'(m_mode == M_RUN));
        end
        model(rs, rd, rpc, st, ms);
        @(posedge clk);
        #1;
        chk("if_valid", 64'(bus.if_valid_o), 64'(m_v));
        chk("if_exc", 64'(bus.if_exc_o), 64'(m_e));
        chk("if_pc", 64'(bus.if_pc_o), 64'(m_ipc));
        chk("if_instr", 64'(bus.if_instr_o), 64'(m_ins));
        chk("cnt_fetch", 64'(bus.cnt_fetch_o), 64'(m_cf));
        chk("cnt_miss", 64'(bus.cnt_miss_o), 64'(m_cm));
    endtask

    task automatic idle();
        step(0, 0, 20'h0, 0, 0);
    endtask

    initial begin
        logic [19:0] rpc;
        bit rd, st, ms, rs;

        rst = 1; sat_inc = 0;
        bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.ic_miss_i = 0;
        @(posedge clk); #1;

        // reset state
        step(1, 0, 20'h0, 0, 0);
        step(1, 0, 20'h0, 0, 0);
        chk("rst_valid", 64'(bus.if_valid_o), 64'd0);
        chk("rst_enable", 64'(bus.ic_enable_o), 64'd0);
        chk("rst_addr", 64'(bus.ic_addr_o), 64'h0);
        chk("rst_cnt_fetch", 64'(bus.cnt_fetch_o), 64'd0);

        // boot cycle then streaming hits
        idle();
        chk("t1_enable_run", 64'(bus.ic_enable_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t1_if_pc", 64'(bus.if_pc_o), 64'(i * 4));
            chk("t1_if_instr", 64'(bus.if_instr_o), {32'h0, 12'hC3A, 20'(i * 4)});
        end

        // 5-cycle miss at 0x10
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 20'h0, 0, 1);
            chk("t2_addr_stable", 64'(bus.ic_addr_o), 64'h10);
            chk("t2_bubble", 64'(bus.if_valid_o), 64'd0);
        end
        idle();
        chk("t2_deliver", 64'(bus.if_pc_o), 64'h10);
        chk("t2_cnt_miss", 64'(bus.cnt_miss_o), 64'd5);

        // decode stall with hits available
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 20'h0, 1, 0);
            chk("t3_pc_frozen", 64'(bus.if_pc_o), 64'h10);
            chk("t3_addr_frozen", 64'(bus.ic_addr_o), 64'h14);
            chk("t3_cnt_frozen", 64'(bus.cnt_fetch_o), 64'd5);
        end
        idle();
        chk("t3_resume", 64'(bus.if_pc_o), 64'h14);

        // redirect to 0x200 during a miss on 0x40
        for (int i = 0; i < 10; i++) idle();
        chk("t4_at_40", 64'(bus.ic_addr_o), 64'h40);
        step(0, 0, 20'h0, 0, 1);
        step(0, 1, 20'h200, 0, 1);
        chk("t4_addr_new", 64'(bus.ic_addr_o), 64'h200);
        step(0, 0, 20'h0, 0, 1);
        step(0, 0, 20'h0, 0, 1);
        chk("t4_no_40", 64'(bus.if_valid_o), 64'd0);
        idle();
        chk("t4_deliver", 64'(bus.if_pc_o), 64'h200);

        // misaligned redirect under stall, then recovery
        step(0, 1, 20'h102, 1, 0);
        chk("t5_exc", 64'(bus.if_exc_o), 64'd1);
        chk("t5_pc", 64'(bus.if_pc_o), 64'h102);
        chk("t5_enable", 64'(bus.ic_enable_o), 64'd0);
        step(0, 0, 20'h0, 1, 0);
        chk("t5_held", 64'(bus.if_valid_o), 64'd1);
        step(0, 1, 20'h300, 0, 0);
        idle();
        chk("t5_refetch", 64'(bus.if_pc_o), 64'h300);
        chk("t5_exc_clr", 64'(bus.if_exc_o), 64'd0);

        // PC wrap at top of address space
        step(0, 1, 20'hFFFFC, 0, 0);
        idle();
        chk("t6_top", 64'(bus.if_pc_o), 64'hFFFFC);
        idle();
        chk("t6_wrap", 64'(bus.if_pc_o), 64'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rs  = ($urandom_range(0, 99) < 2);
            rd  = ($urandom_range(0, 99) < 10);
            st  = ($urandom_range(0, 99) < 25);
            ms  = ($urandom_range(0, 99) < 25);
            rpc = 20'($urandom);
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            step(rs, rd, rpc, st, ms);
        end

        // counter saturation on a narrow instance
        step(1, 0, 20'h0, 0, 0);
        sat_inc = 1;
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 20'h0, 1, 0);
            chk("sat_cnt", 64'(sat_cnt), 64'((k > 7) ? 7 : k));
        end
        sat_inc = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
